// File: rtl/cpu_0_div_pkg.sv
// Shared definitions for the cpu_0 A-stage radix-2 restoring divider.
// The optional early-exit path is enabled by defining CPU_0_DIV_EARLY_EXIT_EN.
package cpu_0_div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    // Quotient returned for a zero divisor.
    localparam logic [DIV_DATA_W-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_e;

endpackage

// File: rtl/cpu_0_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module cpu_0_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_i,
    input  logic              dvd_bit_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W:0]   rem_o,
    output logic              q_bit_o
);

    logic [DATA_W+1:0] diff;

    always_comb begin
        diff    = {rem_i, dvd_bit_i} - {2'b00, dvs_i};
        // The borrow out of the extra top bit means the trial subtraction went negative.
        q_bit_o = ~diff[DATA_W+1];
        rem_o   = q_bit_o ? diff[DATA_W:0] : {rem_i[DATA_W-1:0], dvd_bit_i};
    end

endmodule

// File: rtl/cpu_0_div_cell.sv
// Iterative signed/unsigned divider for the cpu_0 A-stage: fixed DATA_W+2 cycle latency,
// or a two-cycle result for trivial cases when CPU_0_DIV_EARLY_EXIT_EN is defined.
module cpu_0_div_cell
    import cpu_0_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_div_start,
    input  logic              A_div_signed,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    output logic              A_div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_quot,
    output logic [DATA_W-1:0] A_div_rem
);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_quot_q;
    logic              neg_rem_q;
    logic              div0_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W:0]   prem_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] rem_q;

    logic              src1_neg;
    logic              src2_neg;
    logic [DATA_W-1:0] abs_src1;
    logic [DATA_W-1:0] abs_src2;
    logic [DATA_W:0]   step_rem;
    logic              step_qbit;
    logic [DATA_W-1:0] mag_quot;
    logic [DATA_W-1:0] mag_rem;
    logic [DATA_W-1:0] quot_d;
    logic [DATA_W-1:0] rem_d;

    cpu_0_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem_i     (prem_q),
        .dvd_bit_i (dvd_q[DATA_W-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        src1_neg = A_div_signed & A_div_src1[DATA_W-1];
        src2_neg = A_div_signed & A_div_src2[DATA_W-1];
        // Magnitudes are treated as unsigned, so |min_int| = 2**(DATA_W-1) is exact.
        abs_src1 = src1_neg ? -A_div_src1 : A_div_src1;
        abs_src2 = src2_neg ? -A_div_src2 : A_div_src2;

        // In ITER the final step is being taken; from PREP only the trivial results are formed.
        mag_quot = '0;
        mag_rem  = dvd_q;
        if (state_q == ITER) begin
            mag_quot = {dvd_q[DATA_W-2:0], step_qbit};
            mag_rem  = step_rem[DATA_W-1:0];
        end

        quot_d = neg_quot_q ? -mag_quot : mag_quot;
        if (div0_q) begin
            quot_d = DATA_W'(DIV0_QUOT);
        end
        rem_d  = neg_rem_q ? -mag_rem : mag_rem;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            prem_q     <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (A_div_start) begin
                        neg_quot_q <= src1_neg ^ src2_neg;
                        neg_rem_q  <= src1_neg;
                        div0_q     <= (A_div_src2 == '0);
                        dvd_q      <= abs_src1;
                        dvs_q      <= abs_src2;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
`ifdef CPU_0_DIV_EARLY_EXIT_EN
                    if (div0_q || (dvd_q < dvs_q)) begin
                        quot_q  <= quot_d;
                        rem_q   <= rem_d;
                        state_q <= FIX;
                    end else begin
                        prem_q  <= '0;
                        cnt_q   <= CNT_W'(DATA_W - 1);
                        state_q <= ITER;
                    end
`else
                    prem_q  <= '0;
                    cnt_q   <= CNT_W'(DATA_W - 1);
                    state_q <= ITER;
`endif
                end
                ITER: begin
                    prem_q <= step_rem;
                    // The dividend shifts out of the top while quotient bits shift in at the bottom.
                    dvd_q  <= {dvd_q[DATA_W-2:0], step_qbit};
                    if (cnt_q == '0) begin
                        quot_q  <= quot_d;
                        rem_q   <= rem_d;
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign A_div_busy = (state_q != IDLE);
    assign A_div_done = (state_q == FIX);
    assign A_div_quot = quot_q;
    assign A_div_rem  = rem_q;

endmodule

// File: tb/tb_cpu_0_div_cell.sv
// Directed self-checking bench for cpu_0_div_cell (expected values hand-computed).
// Define CPU_0_DIV_EARLY_EXIT_EN here too when the RTL is built with early exit.
module tb_cpu_0_div_cell;

    localparam int LAT = 34;
`ifdef CPU_0_DIV_EARLY_EXIT_EN
    localparam int LAT_SHORT = 2;
`else
    localparam int LAT_SHORT = 34;
`endif

    logic        clk;
    logic        reset;
    logic        A_div_start;
    logic        A_div_signed;
    logic [31:0] A_div_src1;
    logic [31:0] A_div_src2;
    logic        A_div_busy;
    logic        A_div_done;
    logic [31:0] A_div_quot;
    logic [31:0] A_div_rem;

    int total;
    int bad;
    logic [31:0] last_q;
    logic [31:0] last_r;

    cpu_0_div_cell dut (
        .clk          (clk),
        .reset        (reset),
        .A_div_start  (A_div_start),
        .A_div_signed (A_div_signed),
        .A_div_src1   (A_div_src1),
        .A_div_src2   (A_div_src2),
        .A_div_busy   (A_div_busy),
        .A_div_done   (A_div_done),
        .A_div_quot   (A_div_quot),
        .A_div_rem    (A_div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 2000000");
        $fatal(1);
    end

    // Called at a negedge: start is high for this cycle (cycle 0); returns at the negedge of the
    // done cycle, or with done_cyc=-1 after 100 cycles. A second start may be injected at inj_cyc.
    task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input int inj_cyc, output int done_cyc, output logic [31:0] q,
                         output logic [31:0] r, output int busy_err, output int hold_err);
        busy_err = (A_div_busy !== 1'b0) ? 1 : 0;
        hold_err = 0;
        done_cyc = -1;
        q = '0;
        r = '0;
        A_div_signed = sg;
        A_div_src1   = a;
        A_div_src2   = b;
        A_div_start  = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            A_div_start = (c == inj_cyc);
            if (c == inj_cyc) begin
                A_div_src1 = 32'd5;
                A_div_src2 = 32'd5;
            end
            if (A_div_busy !== 1'b1) busy_err++;
            if (A_div_done === 1'b1) begin
                done_cyc = c;
                q = A_div_quot;
                r = A_div_rem;
                break;
            end
            if (A_div_quot !== last_q || A_div_rem !== last_r) hold_err++;
        end
        A_div_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        A_div_start = 1'b0;
        A_div_signed = 1'b0;
        A_div_src1 = '0;
        A_div_src2 = '0;
        repeat (3) @(negedge clk);
        total++;
        if (A_div_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", A_div_busy); end
        total++;
        if (A_div_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", A_div_done); end
        total++;
        if (A_div_quot !== 32'h0) begin bad++; $display("FAIL reset_quot: got %h want 0", A_div_quot); end
        total++;
        if (A_div_rem !== 32'h0) begin bad++; $display("FAIL reset_rem: got %h want 0", A_div_rem); end
        reset = 1'b0;
        last_q = '0;
        last_r = '0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int dc, be, he;
        logic [31:0] q, r;
        do_op(1'b0, 32'd100, 32'd7, 0, dc, q, r, be, he);
        total++;
        if (dc != LAT) begin bad++; $display("FAIL u100_7_latency: got %0d want %0d", dc, LAT); end
        total++;
        if (q !== 32'd14 || r !== 32'd2) begin bad++; $display("FAIL u100_7_result: got q=%h r=%h want q=e r=2", q, r); end
        total++;
        if (be != 0) begin bad++; $display("FAIL u100_7_busy: got %0d bad cycles want 0", be); end
        total++;
        if (he != 0) begin bad++; $display("FAIL u100_7_hold: got %0d changes want 0", he); end
        last_q = 32'd14;
        last_r = 32'd2;
        @(negedge clk);
    endtask

    task automatic test_signed();
        int dc, be, he;
        logic [31:0] q, r;
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, dc, q, r, be, he);
        total++;
        if (dc != LAT || q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL s_m7_2: got cyc=%0d q=%h r=%h want cyc=%0d q=fffffffd r=ffffffff", dc, q, r, LAT);
        end
        total++;
        if (be != 0 || he != 0) begin bad++; $display("FAIL s_m7_2_busy_hold: got %0d/%0d want 0/0", be, he); end
        last_q = 32'hFFFF_FFFD;
        last_r = 32'hFFFF_FFFF;
        @(negedge clk);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, dc, q, r, be, he);
        total++;
        if (dc != LAT || q !== 32'hFFFF_FFFD || r !== 32'd1) begin
            bad++; $display("FAIL s_7_m2: got cyc=%0d q=%h r=%h want cyc=%0d q=fffffffd r=1", dc, q, r, LAT);
        end
        last_q = 32'hFFFF_FFFD;
        last_r = 32'd1;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int dc, be, he;
        logic [31:0] q, r;
        do_op(1'b0, 32'h1234, 32'd0, 0, dc, q, r, be, he);
        total++;
        if (dc != LAT_SHORT) begin bad++; $display("FAIL div0_latency: got %0d want %0d", dc, LAT_SHORT); end
        total++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h1234) begin bad++; $display("FAIL div0_result: got q=%h r=%h want q=ffffffff r=1234", q, r); end
        last_q = 32'hFFFF_FFFF;
        last_r = 32'h1234;
        @(negedge clk);
        do_op(1'b1, 32'hFFFF_FF00, 32'd0, 0, dc, q, r, be, he);
        total++;
        if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FF00) begin bad++; $display("FAIL div0_signed: got q=%h r=%h want q=ffffffff r=ffffff00", q, r); end
        last_q = 32'hFFFF_FFFF;
        last_r = 32'hFFFF_FF00;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int dc, be, he;
        logic [31:0] q, r;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, dc, q, r, be, he);
        total++;
        if (dc != LAT || q !== 32'h8000_0000 || r !== 32'h0) begin
            bad++; $display("FAIL ovf_signed: got cyc=%0d q=%h r=%h want cyc=%0d q=80000000 r=0", dc, q, r, LAT);
        end
        last_q = 32'h8000_0000;
        last_r = 32'h0;
        @(negedge clk);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, dc, q, r, be, he);
        total++;
        if (dc < 0 || q !== 32'h0 || r !== 32'h8000_0000) begin
            bad++; $display("FAIL ovf_unsigned: got cyc=%0d q=%h r=%h want q=0 r=80000000", dc, q, r);
        end
        last_q = 32'h0;
        last_r = 32'h8000_0000;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dc, be, he;
        logic [31:0] q, r;
        do_op(1'b0, 32'd1000, 32'd9, 10, dc, q, r, be, he);
        total++;
        if (dc != LAT || q !== 32'd111 || r !== 32'd1) begin
            bad++; $display("FAIL busy_start_ignored: got cyc=%0d q=%h r=%h want cyc=%0d q=6f r=1", dc, q, r, LAT);
        end
        total++;
        if (he != 0) begin bad++; $display("FAIL busy_start_hold: got %0d changes want 0", he); end
        last_q = 32'd111;
        last_r = 32'd1;
        @(negedge clk);
        total++;
        if (A_div_done !== 1'b0 || A_div_quot !== 32'd111 || A_div_rem !== 32'd1) begin
            bad++; $display("FAIL after_done_hold: got done=%b q=%h r=%h want done=0 q=6f r=1", A_div_done, A_div_quot, A_div_rem);
        end
        do_op(1'b0, 32'd50, 32'd6, 0, dc, q, r, be, he);
        total++;
        if (dc != LAT || q !== 32'd8 || r !== 32'd2 || be != 0) begin
            bad++; $display("FAIL back_to_back: got cyc=%0d q=%h r=%h busyerr=%0d want cyc=%0d q=8 r=2 busyerr=0", dc, q, r, be, LAT);
        end
        last_q = 32'd8;
        last_r = 32'd2;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int dc, be, he;
        logic [31:0] q, r;
        A_div_signed = 1'b0;
        A_div_src1 = 32'h0000_FFFF;
        A_div_src2 = 32'd3;
        A_div_start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            A_div_start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (A_div_busy !== 1'b0 || A_div_done !== 1'b0) begin
            bad++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0/0", A_div_busy, A_div_done);
        end
        total++;
        if (A_div_quot !== 32'h0 || A_div_rem !== 32'h0) begin
            bad++; $display("FAIL midreset_out: got q=%h r=%h want 0/0", A_div_quot, A_div_rem);
        end
        reset = 1'b0;
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        do_op(1'b0, 32'd9, 32'd3, 0, dc, q, r, be, he);
        total++;
        if (dc != LAT || q !== 32'd3 || r !== 32'd0) begin
            bad++; $display("FAIL after_reset_op: got cyc=%0d q=%h r=%h want cyc=%0d q=3 r=0", dc, q, r, LAT);
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
